data_mem_sync: RTL and testbench
================================

# data_mem_sync

Parametrised single-port synchronous data memory with a valid/ready request channel, a registered one-cycle response, an out-of-range error flag and a post-reset zero-fill sweep. It replaces the fixed 64K-word combinational-read data store in the processor datapath: the load/store stage issues one request per cycle and receives a response one cycle later. Contents are deterministic (all zero) after every reset.

## Interface
- DATA_W, 32, word width in bits; multiple of 8.
- ADDR_W, 10, word-address width; DEPTH = 2**ADDR_W words.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables; bit i covers bits [8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at a rising edge.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  address out of range.
- busy  out  1  zero-fill sweep in progress.

## Operation
- States: INIT, RUN. rst low forces INIT, sweep counter 0, rsp_valid/rsp_rdata/rsp_err = 0, busy = 1, req_ready = 0.
- INIT: one word per edge, addresses 0 to DEPTH-1 written with 0. The edge that clears DEPTH-1 moves to RUN; busy drops to 0.
- RUN: req_ready = !rsp_valid || rsp_ready (combinational from registered rsp_valid). req_ready is 0 in INIT.
- In range: req_addr[31:ADDR_W] == 0. Out of range: no array access; response has rsp_err = 1, rsp_rdata = 0.
- Accepted read: rsp_rdata = mem[req_addr[ADDR_W-1:0]] registered at the accept edge.
- Accepted write: array updated at the accept edge; response carries rsp_rdata = 0, rsp_err = 0.
- Every accepted request produces exactly one response, in order. No request is dropped or duplicated.
- Response stalled (rsp_valid && !rsp_ready): rsp_valid, rsp_rdata and rsp_err stay stable; no new accept.
- Response consumed with no new accept: rsp_valid drops to 0 at that edge.
- Memory array is not reset by rst. Only the sweep zeroes it.

## Timing
- Response latency: 1 cycle. A request accepted at edge N has rsp_valid = 1 after edge N.
- Throughput: 1 request/cycle while rsp_ready = 1.
- Write at edge N followed by a read of the same address accepted at edge N+1 returns the new data. The single port makes same-edge read/write impossible.
- After rst deasserts, the first request can be accepted at edge DEPTH+1. req_ready rises after edge DEPTH.
- Reset asserted mid-operation: all outputs return to reset values immediately, asynchronously. Any pending response is discarded. The sweep restarts from 0 after release.

## Configuration
- DMEM_BYTE_WRITE_EN defined: writes merge per byte. Bytes with req_be[i] = 0 keep their old value. req_be = 0 performs no change but still returns a response.
- Undefined: req_be is ignored and every write replaces the full word. The port list is unchanged.

## Test plan
All scenarios use ADDR_W = 4 (DEPTH 16), DATA_W = 32.
- Release reset: busy = 1 and req_ready = 0 for 16 edges, then busy = 0. A read of addr 3 -> rsp_rdata = 0, rsp_err = 0.
- Back-to-back writes of 100 to addr 0 and 29 to addr 1, then back-to-back reads of addr 0 and addr 1 -> responses 100 then 29 on consecutive cycles. A read of addr 1 immediately after its write returns 29.
- Hold rsp_ready = 0 with a read response (value 100) pending -> req_ready = 0 and rsp_rdata held at 100 for 5 cycles. Raise rsp_ready -> the next queued read is accepted that cycle and its response appears next cycle.
- Write 0xDEAD to addr 16 -> rsp_err = 1, rsp_rdata = 0. A subsequent read of addr 0 still returns 100.
- Write 0x11223344 to addr 2 with be = 4'b1111, then write 0xAABBCCDD with be = 4'b0101, then read addr 2. With the macro -> 0x11BB33DD. Without the macro -> 0xAABBCCDD.
- Assert rst while rsp_valid = 1 -> rsp_valid = 0 before the next edge. After the 16-cycle re-sweep, a read of addr 0 -> 0.

Source files
------------

// File: rtl/data_mem_sync.sv
// rtl/data_mem_sync.sv - single-port synchronous data memory with valid/ready request, registered response and post-reset zero-fill
// Optional feature: define DMEM_BYTE_WRITE_EN for per-byte write merging under req_be.
module data_mem_sync #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NBYTES = DATA_W / 8;

    localparam logic S_INIT = 1'b0;
    localparam logic S_RUN  = 1'b1;

    logic                r_state;
    logic [ADDR_W-1:0]   r_sweep_addr;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_run;
    logic                w_accept;
    logic                w_in_range;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_sweep_last;
    logic                w_wr_en;

    assign w_run        = (r_state == S_RUN);
    assign req_ready    = w_run && (!r_rsp_valid || rsp_ready);
    assign w_accept     = req_valid && req_ready;
    assign w_in_range   = (req_addr[31:ADDR_W] == '0);
    assign w_addr       = req_addr[ADDR_W-1:0];
    assign w_sweep_last = (r_sweep_addr == {ADDR_W{1'b1}});
    assign w_wr_en      = w_accept && req_we && w_in_range;

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign busy      = !w_run;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_INIT;
            r_sweep_addr <= '0;
        end else if (!w_run) begin
            r_sweep_addr <= r_sweep_addr + 1'b1;
            if (w_sweep_last) begin
                r_state <= S_RUN;
            end
        end
    end

    // The array has no reset; the sweep is the only thing that makes it deterministic.
    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_mem[r_sweep_addr] <= '0;
        end else if (w_wr_en) begin
`ifdef DMEM_BYTE_WRITE_EN
            for (int i = 0; i < NBYTES; i++) begin
                if (req_be[i]) begin
                    r_mem[w_addr][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
`else
            r_mem[w_addr] <= req_wdata;
`endif
        end
    end

`ifndef DMEM_BYTE_WRITE_EN
    logic w_unused_be;
    assign w_unused_be = ^req_be;
`endif

    // A stalled response holds its payload because nothing is accepted while it waits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= !w_in_range;
            r_rsp_rdata <= (!req_we && w_in_range) ? r_mem[w_addr] : '0;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_mem_sync.sv
// tb/tb_data_mem_sync.sv - scoreboard bench for data_mem_sync (DEPTH 16, 32-bit words)
module tb_data_mem_sync;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [32:0] exp_q[$];

    data_mem_sync #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
        end
    endtask

    // Responses are consumed at the posedge following this negedge, so each is checked once.
    always @(negedge clk) begin
        if (rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got rdata=0x%0h err=%0b want no response", rsp_rdata, rsp_err);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("rsp", {31'd0, rsp_err, rsp_rdata}, {31'd0, e});
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input logic [31:0] er, input logic ee,
                         input bit push, output int waits);
        bit done;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        waits = 0;
        done  = 0;
        while (!done) begin
            @(negedge clk);
            if (req_ready) begin
                done = 1;
                if (push) exp_q.push_back({ee, er});
            end else begin
                waits++;
                if (waits > 50) begin
                    total++;
                    bad++;
                    $display("FAIL accept_timeout: got no accept want accept addr=%0d", addr);
                    done = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input logic [31:0] er, input logic ee);
        int w;
        issue(we, addr, wd, be, er, ee, 1'b1, w);
    endtask

    task automatic sweep_check();
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (i < 15) chk("sweep_busy_ready", {62'd0, busy, req_ready}, 64'd2);
        end
        chk("run_busy_ready", {62'd0, busy, req_ready}, 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int w;
        logic [31:0] exp_merge;
`ifdef DMEM_BYTE_WRITE_EN
        exp_merge = 32'h11BB33DD;
`else
        exp_merge = 32'hAABBCCDD;
`endif
        #2;
        chk("reset_outputs", {29'd0, rsp_valid, rsp_err, busy, req_ready, rsp_rdata}, {29'd0, 4'b0010, 32'd0});
        @(negedge clk);
        rst = 1'b1;
        sweep_check();

        do_req(1'b0, 32'd3, 32'd0, 4'hF, 32'd0, 1'b0);
        do_req(1'b1, 32'd0, 32'd100, 4'hF, 32'd0, 1'b0);
        do_req(1'b1, 32'd1, 32'd29, 4'hF, 32'd0, 1'b0);
        do_req(1'b0, 32'd1, 32'd0, 4'hF, 32'd29, 1'b0);
        do_req(1'b0, 32'd0, 32'd0, 4'hF, 32'd100, 1'b0);
        do_req(1'b0, 32'd1, 32'd0, 4'hF, 32'd29, 1'b0);
        do_req(1'b0, 32'd0, 32'd0, 4'hF, 32'd100, 1'b0);

        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold", {30'd0, req_ready, rsp_valid, rsp_rdata}, {30'd0, 2'b01, 32'd100});
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        issue(1'b0, 32'd1, 32'd0, 4'hF, 32'd29, 1'b0, 1'b1, w);
        chk("stall_release_waits", w, 0);

        do_req(1'b1, 32'd16, 32'hDEAD, 4'hF, 32'd0, 1'b1);
        do_req(1'b0, 32'd0, 32'd0, 4'hF, 32'd100, 1'b0);
        do_req(1'b1, 32'd2, 32'h11223344, 4'hF, 32'd0, 1'b0);
        do_req(1'b1, 32'd2, 32'hAABBCCDD, 4'h5, 32'd0, 1'b0);
        do_req(1'b0, 32'd2, 32'd0, 4'hF, exp_merge, 1'b0);
        drain();

        rsp_ready = 1'b0;
        issue(1'b0, 32'd3, 32'd0, 4'hF, 32'd0, 1'b0, 1'b0, w);
        chk("pre_reset_valid", rsp_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", {29'd0, rsp_valid, rsp_err, busy, req_ready, rsp_rdata}, {29'd0, 4'b0010, 32'd0});
        exp_q.delete();
        rsp_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        sweep_check();
        do_req(1'b0, 32'd0, 32'd0, 4'hF, 32'd0, 1'b0);
        do_req(1'b0, 32'd2, 32'd0, 4'hF, 32'd0, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
